regfile_wb_queue: RTL

//  Write-side initiator for the 16x32 register file. Merges writeback requests from the ALU and

---
 rtl/regfile_wb_queue_pkg.sv | 25 ++
 rtl/regfile_wb_fifo.sv | 76 +++++++
 rtl/regfile_wb_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// Shared register-file definitions used by the register file and its
// writeback queue.
//   REG_ADDR_W / REG_DATA_W / NUM_REGS : register file geometry (16 x 32)
//   wb_entry_t                         : one queued writeback {valid, dest, data}
//   dest_onehot()                      : register index -> one-hot register mask
package regfile_wb_queue_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 16;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [REG_ADDR_W-1:0] dest);
    logic [NUM_REGS-1:0] mask;
    mask       = '0;
    mask[dest] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// In-order storage for the writeback queue: two push slots per cycle and one
// pop per cycle.
//   clk, reset      : clock, asynchronous active-high reset
//   push_a, entry_a : older push of the cycle (written at the tail)
//   push_b, entry_b : younger push of the cycle (written behind entry_a)
//   pop             : remove the head entry at this posedge
//   flush           : discard everything; overrides push and pop
//   count           : occupancy 0..DEPTH
//   rd_ptr          : slot index of the head (oldest) entry
//   head            : the head entry (head.valid=0 when empty)
//   slots           : raw storage, for the pending/forwarding search
// The caller guarantees pushes never exceed free space; a pop and a push can
// therefore never target the same slot in one cycle.
module regfile_wb_fifo
  import regfile_wb_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_a,
  input  wb_entry_t             entry_a,
  input  logic                  push_b,
  input  wb_entry_t             entry_b,
  input  logic                  pop,
  input  logic                  flush,
  output logic [CNT_W-1:0]      count,
  output logic [PTR_W-1:0]      rd_ptr,
  output wb_entry_t             head,
  output wb_entry_t [DEPTH-1:0] slots
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i].valid <= 1'b0;
      end
      wr_ptr   <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop) begin
        mem_q[rd_ptr_q].valid <= 1'b0;
      end
      if (push_a) begin
        mem_q[wr_ptr] <= entry_a;
      end
      // The younger push lands one slot further only if the older one was taken.
      if (push_b) begin
        mem_q[wr_ptr + PTR_W'(push_a)] <= entry_b;
      end
      // Pointers are PTR_W wide, so they wrap modulo DEPTH for free.
      wr_ptr   <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      count_q  <= count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end
  end

  assign count  = count_q;
  assign rd_ptr = rd_ptr_q;
  assign head   = mem_q[rd_ptr_q];
  assign slots  = mem_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback initiator for the 16x32 register file. Merges load-unit and ALU
// writebacks into one in-order queue and drains one entry per cycle onto the
// register file write port. Also publishes a pending-destination bitmap and a
// youngest-match forwarding lookup over the queued entries.
//   clk, reset                       : clock, asynchronous active-high reset
//   mem_valid/mem_ready/dest/data    : load-unit writeback request
//   alu_valid/alu_ready/dest/data    : ALU writeback request
//   flush                            : discard all queued entries and same-cycle pushes
//   wb_stall                         : hold the head; no write issued
//   regWrite, wr, writeData          : register file write port
//   fwd_src, fwd_hit, fwd_data       : forwarding lookup
//   pending                          : bit i set while a queued entry targets register i
//   count                            : occupancy 0..DEPTH
//
// Handshake: a request is taken at a posedge where valid and ready are both
// high (and flush is low). ready is a function of registered occupancy only,
// so it never depends on valid, stall or the same-cycle pop. mem is the older
// of two same-cycle pushes, alu the younger.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_dest,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                flush,
  input  logic                wb_stall,
  output logic                regWrite,
  output logic [ADDR_W-1:0]   wr,
  output logic [DATA_W-1:0]   writeData,
  input  logic [ADDR_W-1:0]   fwd_src,
  output logic                fwd_hit,
  output logic [DATA_W-1:0]   fwd_data,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    count
);

  logic                  mem_push;
  logic                  alu_push;
  logic                  pop;
  wb_entry_t             mem_entry;
  wb_entry_t             alu_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] slots;
  logic [PTR_W-1:0]      rd_ptr;

  // mem needs one free slot; alu needs two so it still fits behind a
  // same-cycle mem push.
  assign mem_ready = (count <= CNT_W'(DEPTH - 1));
  assign alu_ready = (count <= CNT_W'(DEPTH - 2));

  assign mem_push = mem_valid & mem_ready;
  assign alu_push = alu_valid & alu_ready;

  assign mem_entry = '{valid: 1'b1, dest: mem_dest, data: mem_data};
  assign alu_entry = '{valid: 1'b1, dest: alu_dest, data: alu_data};

  // A flush still shows the head on the write port this cycle, but the head
  // is discarded by the flush rather than popped.
  assign pop = head.valid & ~wb_stall & ~flush;

  regfile_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_a  (mem_push),
    .entry_a (mem_entry),
    .push_b  (alu_push),
    .entry_b (alu_entry),
    .pop     (pop),
    .flush   (flush),
    .count   (count),
    .rd_ptr  (rd_ptr),
    .head    (head),
    .slots   (slots)
  );

  assign regWrite  = head.valid & ~wb_stall;
  assign wr        = head.valid ? head.dest : '0;
  assign writeData = head.valid ? head.data : '0;

  // Valid slots are contiguous starting at rd_ptr, so walking oldest to
  // youngest and letting later matches overwrite earlier ones yields the
  // youngest match.
  logic [PTR_W-1:0] idx;
  wb_entry_t        slot;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    pending  = '0;
    idx      = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx  = rd_ptr + PTR_W'(i);
      slot = slots[idx];
      if (slot.valid) begin
        pending = pending | dest_onehot(slot.dest);
        if (slot.dest == fwd_src) begin
          fwd_hit  = 1'b1;
          fwd_data = slot.data;
        end
      end
    end
  end

endmodule
